// File: rtl/mtm_alu_host.sv
// Host-side endpoint of the mtm_Alu serial link: serializes one (A, B, op) command
// frame on tx, then receives and checks the ALU response frame on rx.
module mtm_alu_host #(
    parameter int RSP_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_A,
    input  logic [31:0] req_B,
    input  logic [2:0]  req_op,
    output logic        tx,
    input  logic        rx,
    output logic        rsp_valid,
    output logic [31:0] rsp_C,
    output logic [3:0]  rsp_flags,
    output logic [5:0]  rsp_err_flags,
    output logic [1:0]  rsp_status
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX,
        S_WAIT,
        S_RX,
        S_DONE
    } state_t;

    // Timeout fires on this count so the pulse lands RSP_TIMEOUT cycles after the last stop bit.
    localparam logic [9:0] TO_LAST = 10'(RSP_TIMEOUT - 2);

    function automatic logic [3:0] crc4(input logic [67:0] d);
        logic [3:0] c;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            c = {c[2:0], 1'b0} ^ ({4{c[3] ^ d[i]}} & 4'b0011);
        end
        return c;
    endfunction

    function automatic logic [2:0] crc3(input logic [36:0] d);
        logic [2:0] c;
        c = 3'h0;
        for (int i = 36; i >= 0; i--) begin
            c = {c[1:0], 1'b0} ^ ({3{c[2] ^ d[i]}} & 3'b011);
        end
        return c;
    endfunction

    state_t      state;
    logic [98:0] tx_sr;
    logic [6:0]  bit_cnt;
    logic [2:0]  pkt_cnt;
    logic [9:0]  tcnt;
    logic [8:0]  rx_sr;
    logic [31:0] c_sr;
    logic        frame_err;

    logic [63:0] op_bytes;
    logic [98:0] frame;

    always_comb begin
        op_bytes = {req_B, req_A};
        frame    = '0;
        for (int i = 0; i < 8; i++) begin
            frame[98 - 11*i -: 11] = {2'b00, op_bytes[63 - 8*i -: 8], 1'b1};
        end
        frame[10:0] = {2'b01, 1'b0, req_op, crc4({req_B, req_A, 1'b1, req_op}), 1'b1};
    end

    // Packet being completed: rx_sr holds {type, payload}, rx is the stop bit.
    logic       p_type;
    logic [7:0] p_pay;
    logic       p_stop;
    logic       err_frame_ok;
    logic       norm_ok;

    assign p_type       = rx_sr[8];
    assign p_pay        = rx_sr[7:0];
    assign p_stop       = rx;
    assign err_frame_ok = p_stop & ~(^p_pay);
    assign norm_ok      = ~frame_err & p_type & ~p_pay[7] & p_stop &
                          (crc3({c_sr, 1'b0, p_pay[6:3]}) == p_pay[2:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            tx            <= 1'b1;
            req_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_C         <= '0;
            rsp_flags     <= '0;
            rsp_err_flags <= '0;
            rsp_status    <= 2'b00;
            tx_sr         <= '0;
            bit_cnt       <= '0;
            pkt_cnt       <= '0;
            tcnt          <= '0;
            rx_sr         <= '0;
            c_sr          <= '0;
            frame_err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        tx        <= frame[98];
                        tx_sr     <= {frame[97:0], 1'b1};
                        bit_cnt   <= '0;
                        req_ready <= 1'b0;
                        state     <= S_TX;
                    end
                end
                S_TX: begin
                    if (bit_cnt == 7'd98) begin
                        tx        <= 1'b1;
                        tcnt      <= '0;
                        pkt_cnt   <= '0;
                        frame_err <= 1'b0;
                        state     <= S_WAIT;
                    end else begin
                        tx      <= tx_sr[98];
                        tx_sr   <= {tx_sr[97:0], 1'b1};
                        bit_cnt <= bit_cnt + 7'd1;
                    end
                end
                S_WAIT: begin
                    if (!rx) begin
                        bit_cnt <= '0;
                        state   <= S_RX;
                    end else if (tcnt >= TO_LAST) begin
                        rsp_C         <= '0;
                        rsp_flags     <= '0;
                        rsp_err_flags <= '0;
                        rsp_status    <= 2'b11;
                        rsp_valid     <= 1'b1;
                        state         <= S_DONE;
                    end else if (tcnt != 10'h3FF) begin
                        tcnt <= tcnt + 10'd1;
                    end
                end
                S_RX: begin
                    if (bit_cnt == 7'd9) begin
                        if (pkt_cnt == 3'd0 && p_type && p_pay[7]) begin
                            rsp_C         <= '0;
                            rsp_flags     <= '0;
                            rsp_err_flags <= p_pay[6:1];
                            rsp_status    <= err_frame_ok ? 2'b01 : 2'b10;
                            rsp_valid     <= 1'b1;
                            state         <= S_DONE;
                        end else if (pkt_cnt == 3'd4) begin
                            rsp_C         <= c_sr;
                            rsp_flags     <= p_pay[6:3];
                            rsp_err_flags <= '0;
                            rsp_status    <= norm_ok ? 2'b00 : 2'b10;
                            rsp_valid     <= 1'b1;
                            state         <= S_DONE;
                        end else begin
                            // Framing faults are remembered so the whole frame is still consumed.
                            c_sr      <= {c_sr[23:0], p_pay};
                            frame_err <= frame_err | p_type | ~p_stop;
                            pkt_cnt   <= pkt_cnt + 3'd1;
                            tcnt      <= '0;
                            state     <= S_WAIT;
                        end
                    end else begin
                        rx_sr   <= {rx_sr[7:0], rx};
                        bit_cnt <= bit_cnt + 7'd1;
                    end
                end
                S_DONE: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mtm_alu_host.sv
// Directed bench for mtm_alu_host: drives requests, checks the tx frame, plays the
// ALU side on rx, and scoreboards every rsp_valid against an expected queue.
module tb_mtm_alu_host;
    localparam int RSP_T = 1023;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_A;
    logic [31:0] req_B;
    logic [2:0]  req_op;
    logic        tx;
    logic        rx;
    logic        rsp_valid;
    logic [31:0] rsp_C;
    logic [3:0]  rsp_flags;
    logic [5:0]  rsp_err_flags;
    logic [1:0]  rsp_status;

    int n_vec  = 0;
    int n_miss = 0;
    logic [43:0] exp_q[$];

    always #5 clk = ~clk;

    mtm_alu_host #(.RSP_TIMEOUT(RSP_T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_A(req_A), .req_B(req_B), .req_op(req_op),
        .tx(tx), .rx(rx),
        .rsp_valid(rsp_valid), .rsp_C(rsp_C), .rsp_flags(rsp_flags),
        .rsp_err_flags(rsp_err_flags), .rsp_status(rsp_status)
    );

    task automatic report();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: CRC as remainder of polynomial long division (message * x^n).
    function automatic logic [3:0] crc4_div(input logic [67:0] m);
        logic [71:0] r;
        r = {m, 4'h0};
        for (int i = 71; i >= 4; i--) if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    function automatic logic [2:0] crc3_div(input logic [36:0] m);
        logic [39:0] r;
        r = {m, 3'h0};
        for (int i = 39; i >= 3; i--) if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
        return r[2:0];
    endfunction

    function automatic logic [10:0] pkt(input logic t, input logic [7:0] d);
        return {1'b0, t, d, 1'b1};
    endfunction

    function automatic logic [98:0] exp_frame(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        return {pkt(1'b0, b[31:24]), pkt(1'b0, b[23:16]), pkt(1'b0, b[15:8]), pkt(1'b0, b[7:0]),
                pkt(1'b0, a[31:24]), pkt(1'b0, a[23:16]), pkt(1'b0, a[15:8]), pkt(1'b0, a[7:0]),
                pkt(1'b1, {1'b0, op, crc4_div({b, a, 1'b1, op})})};
    endfunction

    function automatic logic [54:0] norm_rsp(input logic [31:0] c, input logic [3:0] fl);
        return {pkt(1'b0, c[31:24]), pkt(1'b0, c[23:16]), pkt(1'b0, c[15:8]), pkt(1'b0, c[7:0]),
                pkt(1'b1, {1'b0, fl, crc3_div({c, 1'b0, fl})})};
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL rsp_unexpected: got rsp_valid with status %b, expected no response at %0t",
                         rsp_status, $time);
            end else begin
                check("rsp_fields", 128'({rsp_C, rsp_flags, rsp_err_flags, rsp_status}),
                      128'(exp_q.pop_front()));
            end
        end
    end

    task automatic accept_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        int waited;
        waited = 0;
        @(negedge clk);
        req_A = a; req_B = b; req_op = op; req_valid = 1'b1;
        while (!req_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 3000) begin
                n_vec++;
                n_miss++;
                $display("FAIL accept_wait: got req_ready 0, expected 1 within 3000 cycles");
                report();
            end
        end
        @(posedge clk);
    endtask

    // Called right after the accepting edge; samples all 99 tx bits and scrambles req_*.
    task automatic capture_tx(input bit noise, output logic [98:0] f);
        for (int i = 0; i < 99; i++) begin
            @(negedge clk);
            f[98 - i] = tx;
            if (i == 0) begin
                check("ready_low_after_accept", 128'(req_ready), 128'(0));
                req_valid = 1'b0;
                req_A = ~req_A; req_B = ~req_B; req_op = ~req_op;
            end
            if (noise) rx = (i >= 20 && i < 40) ? i[0] : 1'b1;
        end
    endtask

    task automatic do_request(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                              input bit noise, output logic [98:0] f);
        accept_req(a, b, op);
        capture_tx(noise, f);
        check("tx_frame", 128'(f), 128'(exp_frame(a, b, op)));
    endtask

    task automatic reply(input logic [54:0] bits, input int n, input int gap);
        repeat (gap) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            rx = bits[i];
        end
    endtask

    task automatic expect_pulse();
        @(negedge clk);
        rx = 1'b1;
        check("rsp_valid_pulse", 128'(rsp_valid), 128'(1));
        @(negedge clk);
        check("rsp_valid_one_cycle", 128'(rsp_valid), 128'(0));
        check("ready_returns", 128'(req_ready), 128'(1));
    endtask

    initial begin
        logic [98:0] f;
        logic [54:0] r;
        int waited;

        rst = 1'b1; rx = 1'b1; req_valid = 1'b0;
        req_A = '0; req_B = '0; req_op = '0;
        repeat (3) @(negedge clk);
        check("reset_tx", 128'(tx), 128'(1));
        check("reset_ready", 128'(req_ready), 128'(1));
        check("reset_valid", 128'(rsp_valid), 128'(0));
        check("reset_fields", 128'({rsp_C, rsp_flags, rsp_err_flags, rsp_status}), 128'(0));
        rst = 1'b0;

        // AND, with rx chatter during TX that must be ignored
        do_request(32'hFFFF0000, 32'h0F0F0F0F, 3'b000, 1'b1, f);
        check("and_first_pkt", 128'(f[98:88]), 128'(11'h01F));
        exp_q.push_back({32'h0F0F0000, 4'b0000, 6'b000000, 2'b00});
        reply(norm_rsp(32'h0F0F0000, 4'b0000), 55, 2);
        expect_pulse();

        // ADD, then a back-to-back SUB held valid across rsp_valid
        do_request(32'hFFFFFFFF, 32'h00000001, 3'b100, 1'b0, f);
        exp_q.push_back({32'h00000000, 4'b1010, 6'b000000, 2'b00});
        req_A = 32'h00000005; req_B = 32'h00000007; req_op = 3'b101; req_valid = 1'b1;
        reply(norm_rsp(32'h00000000, 4'b1010), 55, 3);
        @(negedge clk);
        rx = 1'b1;
        check("add_rsp_valid_pulse", 128'(rsp_valid), 128'(1));
        @(negedge clk);
        check("b2b_ready_rises", 128'(req_ready), 128'(1));
        @(posedge clk);
        capture_tx(1'b0, f);
        check("b2b_tx_frame", 128'(f), 128'(exp_frame(32'h00000005, 32'h00000007, 3'b101)));
        exp_q.push_back({32'hFFFFFFFE, 4'b1001, 6'b000000, 2'b00});
        reply(norm_rsp(32'hFFFFFFFE, 4'b1001), 55, 1);
        expect_pulse();

        // Error frame, good parity then flipped parity
        do_request(32'h12340000, 32'h00005678, 3'b111, 1'b0, f);
        exp_q.push_back({32'h0, 4'b0000, 6'b001001, 2'b01});
        reply(55'(pkt(1'b1, 8'h93)), 11, 2);
        expect_pulse();

        do_request(32'h12340000, 32'h00005678, 3'b110, 1'b0, f);
        exp_q.push_back({32'h0, 4'b0000, 6'b001001, 2'b10});
        reply(55'(pkt(1'b1, 8'h92)), 11, 2);
        expect_pulse();

        // Bad CRC3: received C still reported
        do_request(32'h00000001, 32'h00000002, 3'b100, 1'b0, f);
        exp_q.push_back({32'h00000003, 4'b0000, 6'b000000, 2'b10});
        r = norm_rsp(32'h00000003, 4'b0000) ^ 55'h2;
        reply(r, 55, 4);
        expect_pulse();

        // Stop bit 0 in the second DATA packet
        do_request(32'h40000000, 32'h40000000, 3'b100, 1'b0, f);
        exp_q.push_back({32'h80000000, 4'b0101, 6'b000000, 2'b10});
        r = norm_rsp(32'h80000000, 4'b0101) ^ (55'h1 << 33);
        reply(r, 55, 2);
        expect_pulse();

        // Timeout: silent ALU
        do_request(32'h00000007, 32'h00000009, 3'b101, 1'b0, f);
        exp_q.push_back({32'h0, 4'b0000, 6'b000000, 2'b11});
        for (int i = 1; i <= RSP_T; i++) begin
            @(negedge clk);
            if (i == RSP_T - 1) check("timeout_not_early", 128'(rsp_valid), 128'(0));
        end
        check("timeout_exact", 128'(rsp_valid), 128'(1));
        @(negedge clk);
        check("timeout_one_cycle", 128'(rsp_valid), 128'(0));
        check("timeout_ready_returns", 128'(req_ready), 128'(1));

        // Abort at tx bit 40 with an asynchronous mid-cycle reset
        accept_req(32'h11111111, 32'h00000000, 3'b101);
        for (int i = 0; i <= 40; i++) begin
            @(negedge clk);
            if (i == 0) req_valid = 1'b0;
        end
        check("abort_tx_bit40", 128'(tx), 128'(exp_frame(32'h11111111, 32'h0, 3'b101) >> 58) & 128'(1));
        #2 rst = 1'b1;
        #1;
        check("abort_tx_high", 128'(tx), 128'(1));
        check("abort_ready", 128'(req_ready), 128'(1));
        check("abort_valid", 128'(rsp_valid), 128'(0));
        check("abort_status", 128'(rsp_status), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_tx_idle", 128'(tx), 128'(1));

        do_request(32'hA5A5A5A5, 32'h5A5A5A5A, 3'b001, 1'b0, f);
        exp_q.push_back({32'hFFFFFFFF, 4'b0001, 6'b000000, 2'b00});
        reply(norm_rsp(32'hFFFFFFFF, 4'b0001), 55, 2);
        expect_pulse();

        waited = 0;
        while (exp_q.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("queue_drained", 128'(exp_q.size()), 128'(0));
        report();
    end

    initial begin
        #2000000;
        n_vec++;
        n_miss++;
        $display("FAIL watchdog: got no completion, expected finish before 2 ms");
        report();
    end

endmodule

// File: doc/mtm_alu_host.md
# mtm_alu_host

Host-side serial endpoint for the `mtm_Alu` serial protocol: the opposite end of the ALU's `sin`/`sout` link. It accepts one operation (A, B, opcode) over a valid/ready interface and serializes it into a 9-packet command frame on `tx`. It then deserializes the ALU's response frame from `rx`, checks it, and presents the result with a status code. It sits in the test/system harness, with `tx` driving the ALU's `sin` and `rx` driven by the ALU's `sout`.

## Interface
- `RSP_TIMEOUT`, default 1023: cycles to wait for a response start bit before declaring a timeout.
- `clk`  in  1  posedge clock; one serial bit per cycle.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  host idle and able to accept.
- `req_A`  in  32  operand A.
- `req_B`  in  32  operand B.
- `req_op`  in  3  opcode, sent verbatim (AND 000, OR 001, ADD 100, SUB 101; other codes allowed for error tests).
- `tx`  out  1  serial out to ALU `sin`; idles high.
- `rx`  in  1  serial in from ALU `sout`; idles high.
- `rsp_valid`  out  1  one-cycle pulse; response fields valid.
- `rsp_C`  out  32  result.
- `rsp_flags`  out  4  {carry, overflow, zero, negative}.
- `rsp_err_flags`  out  6  {ERR_DATA, ERR_CRC, ERR_OP, ERR_DATA, ERR_CRC, ERR_OP} from the error frame.
- `rsp_status`  out  2  00 OK, 01 ALU error frame, 10 bad CRC3/parity/framing, 11 timeout.

## Operation
- **Packet format:** 11 bits, sent MSB-first in this order: start 0, type (0 DATA, 1 CTL), 8 payload bits, stop 1.
- **Command frame:** 9 packets, 99 bits.
  - 8 DATA packets: B[31:24], B[23:16], B[15:8], B[7:0], then A[31:24] … A[7:0].
  - 1 CTL packet with payload {0, op[2:0], CRC4[3:0]}.
  - CRC4 uses polynomial x^4+x+1, init 0, computed over the 68-bit vector {B, A, 1'b1, op} MSB-first.
- **Normal response:** 5 packets.
  - 4 DATA packets: C[31:24] … C[7:0].
  - 1 CTL packet with payload {0, flags[3:0], CRC3[2:0]}.
  - CRC3 uses polynomial x^3+x+1, init 0, computed over {C, 1'b0, flags} (37 bits).
- **Error response:** a single CTL packet with payload {1, err_flags[5:0], parity}. Parity is even over the 7 preceding payload bits.
- **Receiver:**
  - Samples `rx` each cycle. A 0 in an idle/wait position is a start bit; the next 10 bits are captured.
  - If the first received packet is CTL with payload bit 7 = 1, it is an error frame.
  - Otherwise 4 DATA packets followed by 1 CTL packet are expected.
  - A type mismatch, or stop bit = 0, is a framing error and gives status 10.
- **States:**
  - IDLE: `req_ready`=1; accepting a request goes to TX.
  - TX: 99-bit counter; at bit 98 go to WAIT.
  - WAIT: timeout counter runs; a start bit goes to RX; timeout expiry goes to DONE with status 11.
  - RX: packet and bit counters; between packets, return to inter-packet wait, where the timeout counter restarts.
  - DONE: `rsp_valid`=1 for 1 cycle, then IDLE.
- Requests are latched on acceptance. Changes to `req_*` after acceptance have no effect.
- **Output values by status:**
  - Status 10 after a normal frame: `rsp_C`/`rsp_flags` still carry the received values.
  - Status 01: `rsp_C`=0 and `rsp_flags`=0.
  - Status 11: all data fields are 0.

## Timing
- **Reset values:** `tx`=1, `req_ready`=1, `rsp_valid`=0, `rsp_C`=0, `rsp_flags`=0, `rsp_err_flags`=0, `rsp_status`=00. State is IDLE and all counters are 0.
- **Reset mid-operation:** aborts immediately and sets `tx` high. No `rsp_valid` is issued for the aborted request.
- **Request acceptance:** `req_valid && req_ready` at edge N. `req_ready` is low from N+1. The first start bit appears on `tx` in cycle N+1, and the last stop bit in cycle N+99.
- **Between frames:** `tx` is held at 1 outside TX.
- **Response completion:** `rsp_valid` pulses in the cycle after the final stop bit is sampled. `req_ready` returns to 1 the cycle after that pulse.
- **Response hold:** `rsp_*` fields are held until the next `rsp_valid`.
- **Timeout:** in WAIT, `RSP_TIMEOUT` consecutive idle cycles trigger it. The counter is 10 bits wide and saturates; it does not wrap.
- **Early `rx` activity:** `rx` activity during TX is ignored; the receiver arms at the first WAIT cycle.
- **Back-to-back requests:** `req_valid` held high across `rsp_valid` gives a new accept on the first cycle `req_ready`=1.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → `tx`=1, `req_ready`=1, `rsp_valid`=0, `rsp_status`=00 without waiting for a clock edge.
- **AND:** A=0xFFFF0000, B=0x0F0F0F0F, op=000 → first `tx` packet is 0,0,0x0F,1 and the frame is 99 bits with CRC4 per rule. ALU model replies C=0x0F0F0000, flags 0000 → one-cycle `rsp_valid`, `rsp_C`=0x0F0F0000, status 00.
- **ADD:** A=0xFFFFFFFF, B=1, op=100, model replies C=0, flags 1010 → `rsp_flags`=1010, status 00; back-to-back second request accepted the cycle after `req_ready` rises.
- **Error frame:** model replies payload {1,001001,p} with even parity → status 01, `rsp_err_flags`=001001, `rsp_C`=0. The same frame with parity flipped → status 10.
- **Bad CRC3 / framing:** flip 1 CRC3 bit → status 10 and `rsp_C` carries the received value. Stop bit 0 in DATA packet 2 → status 10.
- **Timeout and abort:** model silent → `rsp_valid` with status 11 exactly `RSP_TIMEOUT` cycles after the last tx stop bit. `rst` pulsed at tx bit 40 → `tx`=1 immediately, no `rsp_valid`, and the next request transmits normally.
